// File: rtl/divider_pkg.sv
// Shared arithmetic definitions for the sequential divider: FSM state type and counter sizing.
package divider_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } div_state_t;

    // Iteration counter must hold 0 .. 2*width.
    function automatic int cnt_width(input int width);
        return $clog2(2 * width + 1);
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit, subtract if it fits.
module div_step #(
    parameter int WIDTH = 8
) (
    input  logic [WIDTH-1:0] r_in,
    input  logic             bit_in,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] r_out,
    output logic             q_bit
);

    // The stored remainder is always below the divisor, so only the shifted value needs WIDTH+1 bits.
    logic [WIDTH:0] r_sh;

    assign r_sh  = {r_in, bit_in};
    assign q_bit = (r_sh >= {1'b0, divisor});
    assign r_out = q_bit ? (r_sh[WIDTH-1:0] - divisor) : r_sh[WIDTH-1:0];

endmodule

// File: rtl/divider.sv
// Sequential restoring divider, one quotient bit per clock; done 2*WIDTH edges after acceptance, start ignored while busy.
// DIVIDER_DIV0_CHECK_EN: zero divisor exits after a single RUN cycle and flags div_by_zero.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [2*WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0]   divisor,
    output logic               busy,
    output logic               done,
    output logic [2*WIDTH-1:0] quotient,
    output logic [WIDTH-1:0]   remainder,
    output logic               div_by_zero
);

    localparam int DW = 2 * WIDTH;
    localparam int CW = cnt_width(WIDTH);
    localparam logic [CW-1:0] LAST_ITER = CW'(DW - 1);

    div_state_t       state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic [DW-1:0]    dvd_q, dvd_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [DW-1:0]    quo_q, quo_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] r_nx;
    logic             q_bit;
    logic             accept;
`ifdef DIVIDER_DIV0_CHECK_EN
    logic             dbz_q, dbz_d;
`endif

    div_step #(.WIDTH(WIDTH)) u_step (
        .r_in    (r_q),
        .bit_in  (dvd_q[DW-1]),
        .divisor (dvs_q),
        .r_out   (r_nx),
        .q_bit   (q_bit)
    );

    assign accept = start && (state_q != ST_RUN);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        r_d     = r_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        quo_d   = quo_q;
        rem_d   = rem_q;
`ifdef DIVIDER_DIV0_CHECK_EN
        dbz_d   = dbz_q;
`endif
        case (state_q)
            ST_RUN: begin
`ifdef DIVIDER_DIV0_CHECK_EN
                if (dvs_q == '0) begin
                    state_d = ST_DONE;
                    quo_d   = '1;
                    rem_d   = dvd_q[WIDTH-1:0];
                    dbz_d   = 1'b1;
                end else
`endif
                begin
                    // Quotient bits shift in behind the dividend bits as they are consumed.
                    r_d   = r_nx;
                    dvd_d = {dvd_q[DW-2:0], q_bit};
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == LAST_ITER) begin
                        state_d = ST_DONE;
                        quo_d   = {dvd_q[DW-2:0], q_bit};
                        rem_d   = r_nx;
`ifdef DIVIDER_DIV0_CHECK_EN
                        dbz_d   = 1'b0;
`endif
                    end
                end
            end
            ST_DONE: state_d = ST_IDLE;
            default: state_d = state_q;
        endcase
        if (accept) begin
            state_d = ST_RUN;
            cnt_d   = '0;
            r_d     = '0;
            dvd_d   = dividend;
            dvs_d   = divisor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            r_q     <= '0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
`ifdef DIVIDER_DIV0_CHECK_EN
            dbz_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            r_q     <= r_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
`ifdef DIVIDER_DIV0_CHECK_EN
            dbz_q   <= dbz_d;
`endif
        end
    end

    assign busy      = (state_q == ST_RUN);
    assign done      = (state_q == ST_DONE);
    assign quotient  = quo_q;
    assign remainder = rem_q;
`ifdef DIVIDER_DIV0_CHECK_EN
    assign div_by_zero = dbz_q;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: WIDTH=8 directed/random scenarios and WIDTH=4 exhaustive sweep.
module tb_divider;

    logic        clk = 1'b0;
    logic        rst;

    logic        start8;
    logic [15:0] dvd8;
    logic [7:0]  dvs8;
    logic        busy8, done8, dbz8;
    logic [15:0] quo8;
    logic [7:0]  rem8;

    logic        start4;
    logic [7:0]  dvd4;
    logic [3:0]  dvs4;
    logic        busy4, done4, dbz4;
    logic [7:0]  quo4;
    logic [3:0]  rem4;

    int tests = 0;
    int fails = 0;

`ifdef DIVIDER_DIV0_CHECK_EN
    localparam bit DBZ_EN = 1'b1;
`else
    localparam bit DBZ_EN = 1'b0;
`endif

    always #5 clk = ~clk;

    divider #(.WIDTH(8)) u_dut8 (
        .clk         (clk),
        .rst         (rst),
        .start       (start8),
        .dividend    (dvd8),
        .divisor     (dvs8),
        .busy        (busy8),
        .done        (done8),
        .quotient    (quo8),
        .remainder   (rem8),
        .div_by_zero (dbz8)
    );

    divider #(.WIDTH(4)) u_dut4 (
        .clk         (clk),
        .rst         (rst),
        .start       (start4),
        .dividend    (dvd4),
        .divisor     (dvs4),
        .busy        (busy4),
        .done        (done4),
        .quotient    (quo4),
        .remainder   (rem4),
        .div_by_zero (dbz4)
    );

    // Reference model: plain integer division, with the defined divide-by-zero result.
    function automatic logic [15:0] ref_q8(input logic [15:0] a, input logic [7:0] b);
        if (b == 8'd0) return 16'hFFFF;
        return a / {8'd0, b};
    endfunction

    function automatic logic [7:0] ref_r8(input logic [15:0] a, input logic [7:0] b);
        logic [15:0] t;
        if (b == 8'd0) return a[7:0];
        t = a % {8'd0, b};
        return t[7:0];
    endfunction

    function automatic logic [7:0] ref_q4(input logic [7:0] a, input logic [3:0] b);
        if (b == 4'd0) return 8'hFF;
        return a / {4'd0, b};
    endfunction

    function automatic logic [3:0] ref_r4(input logic [7:0] a, input logic [3:0] b);
        logic [7:0] t;
        if (b == 4'd0) return a[3:0];
        t = a % {4'd0, b};
        return t[3:0];
    endfunction

    // Issue one WIDTH=8 operation from IDLE/DONE; lat counts edges from acceptance to done.
    task automatic run_op8(input logic [15:0] a, input logic [7:0] b, output int lat, output int bcnt);
        @(posedge clk); #1;
        start8 = 1'b1; dvd8 = a; dvs8 = b;
        @(posedge clk); #1;
        start8 = 1'b0; dvd8 = 16'($urandom); dvs8 = 8'($urandom);
        lat = 0; bcnt = 0;
        while (done8 !== 1'b1 && lat < 60) begin
            if (busy8 === 1'b1) bcnt++;
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        start8 = 1'b0; dvd8 = '0; dvs8 = '0;
        start4 = 1'b0; dvd4 = '0; dvs4 = '0;
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if ({busy8, done8, quo8, rem8, dbz8} !== 27'd0) begin
            fails++;
            $display("FAIL reset8: busy=%b done=%b q=%h r=%h dbz=%b, required all 0", busy8, done8, quo8, rem8, dbz8);
        end
        tests++;
        if ({busy4, done4, quo4, rem4, dbz4} !== 15'd0) begin
            fails++;
            $display("FAIL reset4: busy=%b done=%b q=%h r=%h dbz=%b, required all 0", busy4, done4, quo4, rem4, dbz4);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        logic [15:0] va [4] = '{16'd1000, 16'hFFFF, 16'hFFFF, 16'd5};
        logic [7:0]  vb [4] = '{8'd7, 8'hFF, 8'd1, 8'd9};
        logic [15:0] eq [4] = '{16'd142, 16'd257, 16'hFFFF, 16'd0};
        logic [7:0]  er [4] = '{8'd6, 8'd0, 8'd0, 8'd5};
        int lat, bcnt;
        for (int i = 0; i < 4; i++) begin
            run_op8(va[i], vb[i], lat, bcnt);
            tests++;
            if (quo8 !== eq[i] || rem8 !== er[i] || dbz8 !== 1'b0) begin
                fails++;
                $display("FAIL basic%0d result: q=%0d r=%0d dbz=%b, required q=%0d r=%0d dbz=0", i, quo8, rem8, dbz8, eq[i], er[i]);
            end
            tests++;
            if (lat != 16 || bcnt != 16) begin
                fails++;
                $display("FAIL basic%0d timing: latency=%0d busy_cycles=%0d, required 16/16", i, lat, bcnt);
            end
        end
        @(posedge clk); #1;
        tests++;
        if (done8 !== 1'b0 || busy8 !== 1'b0 || quo8 !== 16'd0 || rem8 !== 8'd5) begin
            fails++;
            $display("FAIL hold: done=%b busy=%b q=%0d r=%0d, required done=0 busy=0 q=0 r=5", done8, busy8, quo8, rem8);
        end
    endtask

    task automatic test_div0();
        int lat, bcnt;
        run_op8(16'h1234, 8'd0, lat, bcnt);
        tests++;
        if (quo8 !== 16'hFFFF || rem8 !== 8'h34 || dbz8 !== DBZ_EN) begin
            fails++;
            $display("FAIL div0 result: q=%h r=%h dbz=%b, required q=ffff r=34 dbz=%b", quo8, rem8, dbz8, DBZ_EN);
        end
        tests++;
        if (lat != (DBZ_EN ? 1 : 16) || bcnt != (DBZ_EN ? 1 : 16)) begin
            fails++;
            $display("FAIL div0 timing: latency=%0d busy_cycles=%0d, required %0d", lat, bcnt, DBZ_EN ? 1 : 16);
        end
        run_op8(16'd9, 8'd3, lat, bcnt);
        tests++;
        if (quo8 !== 16'd3 || rem8 !== 8'd0 || dbz8 !== 1'b0 || lat != 16) begin
            fails++;
            $display("FAIL div0 clear: q=%0d r=%0d dbz=%b lat=%0d, required q=3 r=0 dbz=0 lat=16", quo8, rem8, dbz8, lat);
        end
    endtask

    task automatic test_back_to_back();
        int lat, bcnt;
        run_op8(16'd1000, 8'd7, lat, bcnt);
        // Still in the DONE cycle: issue the next operation immediately.
        start8 = 1'b1; dvd8 = 16'd100; dvs8 = 8'd3;
        @(posedge clk); #1;
        start8 = 1'b0;
        tests++;
        if (busy8 !== 1'b1 || done8 !== 1'b0) begin
            fails++;
            $display("FAIL b2b accept: busy=%b done=%b, required busy=1 done=0", busy8, done8);
        end
        lat = 0;
        while (done8 !== 1'b1 && lat < 60) begin
            if (lat % 3 == 1) begin
                start8 = 1'b1; dvd8 = 16'($urandom); dvs8 = 8'($urandom);
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            lat++;
        end
        start8 = 1'b0;
        tests++;
        if (lat != 16 || quo8 !== 16'd33 || rem8 !== 8'd1) begin
            fails++;
            $display("FAIL b2b result: latency=%0d q=%0d r=%0d, required 16 q=33 r=1", lat, quo8, rem8);
        end
        @(posedge clk); #1;
        tests++;
        if (busy8 !== 1'b0 || done8 !== 1'b0) begin
            fails++;
            $display("FAIL b2b ignored starts: busy=%b done=%b, required 0 0", busy8, done8);
        end
    endtask

    task automatic test_reset_mid_run();
        int lat, bcnt;
        bit saw_done;
        @(posedge clk); #1;
        start8 = 1'b1; dvd8 = 16'd1000; dvs8 = 8'd7;
        @(posedge clk); #1;
        start8 = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst = 1'b1;
        #1;
        tests++;
        if ({busy8, done8, quo8, rem8, dbz8} !== 27'd0) begin
            fails++;
            $display("FAIL reset mid-run: busy=%b done=%b q=%h r=%h dbz=%b, required all 0", busy8, done8, quo8, rem8, dbz8);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        saw_done = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (done8 === 1'b1 || busy8 === 1'b1) saw_done = 1'b1;
        end
        tests++;
        if (saw_done !== 1'b0) begin
            fails++;
            $display("FAIL reset abort: saw_activity=%b, required 0", saw_done);
        end
        run_op8(16'd200, 8'd9, lat, bcnt);
        tests++;
        if (quo8 !== 16'd22 || rem8 !== 8'd2 || lat != 16) begin
            fails++;
            $display("FAIL after reset: q=%0d r=%0d lat=%0d, required q=22 r=2 lat=16", quo8, rem8, lat);
        end
    endtask

    task automatic test_random8();
        int lat, bcnt;
        logic [15:0] a;
        logic [7:0]  b;
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 5) == 0) ? 8'd0 : 8'($urandom);
            if (i % 4 == 1) a = 16'($urandom_range(0, 255) * $urandom_range(0, 255));
            run_op8(a, b, lat, bcnt);
            tests++;
            if (quo8 !== ref_q8(a, b) || rem8 !== ref_r8(a, b) || dbz8 !== (DBZ_EN && b == 8'd0)
                || lat != ((DBZ_EN && b == 8'd0) ? 1 : 16)) begin
                fails++;
                $display("FAIL rand8 %0d/%0d: q=%0d r=%0d dbz=%b lat=%0d, required q=%0d r=%0d dbz=%b lat=%0d",
                         a, b, quo8, rem8, dbz8, lat, ref_q8(a, b), ref_r8(a, b),
                         DBZ_EN && b == 8'd0, (DBZ_EN && b == 8'd0) ? 1 : 16);
            end
        end
    endtask

    task automatic test_exhaustive4();
        int lat;
        logic [7:0] a;
        logic [3:0] b;
        @(posedge clk); #1;
        for (int i = 0; i < 4096; i++) begin
            a = i[11:4];
            b = i[3:0];
            start4 = 1'b1; dvd4 = a; dvs4 = b;
            @(posedge clk); #1;
            start4 = 1'b0;
            lat = 0;
            while (done4 !== 1'b1 && lat < 40) begin
                @(posedge clk); #1;
                lat++;
            end
            tests++;
            if (quo4 !== ref_q4(a, b) || rem4 !== ref_r4(a, b) || dbz4 !== (DBZ_EN && b == 4'd0)
                || lat != ((DBZ_EN && b == 4'd0) ? 1 : 8)) begin
                fails++;
                $display("FAIL exh4 %0d/%0d: q=%0d r=%0d dbz=%b lat=%0d, required q=%0d r=%0d dbz=%b lat=%0d",
                         a, b, quo4, rem4, dbz4, lat, ref_q4(a, b), ref_r4(a, b),
                         DBZ_EN && b == 4'd0, (DBZ_EN && b == 4'd0) ? 1 : 8);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_div0();
        test_back_to_back();
        test_reset_mid_run();
        test_random8();
        test_exhaustive4();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
